// File: rtl/csr_test_host.sv
// csr_test_host: Avalon-MM initiator that writes test params, sets start, polls status, reads results.
// Latency: first write 1 cycle after accepted start; first status read POLL_INTERVAL+1 cycles after start-bit write.
// Backpressure: none on the bus (fixed 1-cycle read latency); start_i ignored while busy; abort_i always wins.
// Optional feature macro: POLL_TIMEOUT_EN (give up after TIMEOUT_POLLS unsuccessful status reads).
module csr_test_host #(
  parameter int unsigned POLL_INTERVAL = 16,
  parameter int unsigned TIMEOUT_POLLS = 1024
) (
  input  logic              clk_sys_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [3:1][31:0]  test_param_i,
  output logic              read_o,
  output logic              write_o,
  output logic [3:0]        address_o,
  output logic [31:0]       writedata_o,
  input  logic [31:0]       readdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_o,
  output logic [9:0][31:0]  result_o
);

  // Wait counter carries one spare bit above what POLL_INTERVAL needs.
  localparam int unsigned CW = $clog2(POLL_INTERVAL + 1) + 1;

  if (POLL_INTERVAL < 1 || TIMEOUT_POLLS < 1) begin : g_param_chk
    $error("csr_test_host: POLL_INTERVAL and TIMEOUT_POLLS must be >= 1");
  end

  typedef enum logic [3:0] {
    IDLE, WR_PARAM, WR_START, POLL_WAIT, POLL_RD, POLL_CHK, RD_RES, RD_LAST, FINISH
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       idx;        // beat index inside WR_PARAM (0..2) and RD_RES (0..9)
  logic [CW-1:0]    wait_cnt;
  logic [3:1][31:0] params;
  logic             start_acc;

  assign start_acc = (state == IDLE) && start_i && !abort_i;

`ifdef POLL_TIMEOUT_EN
  localparam int unsigned PW = $clog2(TIMEOUT_POLLS + 1);
  logic [PW-1:0] poll_cnt;
  logic [PW:0]   poll_inc;
  logic          timeout_set;
  logic          timeout_q;

  assign poll_inc  = {1'b0, poll_cnt} + {{PW{1'b0}}, 1'b1};
  assign timeout_o = timeout_q;

  // Count unsuccessful status reads since the last accepted start; latch timeout.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      poll_cnt  <= '0;
      timeout_q <= 1'b0;
    end else if (start_acc) begin
      poll_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == POLL_CHK && !readdata_i[0] && !abort_i) poll_cnt <= poll_inc[PW-1:0];
      if (timeout_set) timeout_q <= 1'b1;
    end
  end
`else
  assign timeout_o = 1'b0;
`endif

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_nxt = state;
`ifdef POLL_TIMEOUT_EN
    timeout_set = 1'b0;
`endif
    case (state)
      IDLE:      if (start_i) state_nxt = WR_PARAM;
      WR_PARAM:  if (idx == 4'd2) state_nxt = WR_START;
      WR_START:  state_nxt = POLL_WAIT;
      POLL_WAIT: if (wait_cnt == CW'(POLL_INTERVAL - 1)) state_nxt = POLL_RD;
      POLL_RD:   state_nxt = POLL_CHK;
      POLL_CHK: begin
        if (readdata_i[0]) begin
          state_nxt = RD_RES;
        end else begin
          state_nxt = POLL_WAIT;
`ifdef POLL_TIMEOUT_EN
          if (poll_inc == (PW+1)'(TIMEOUT_POLLS)) begin
            state_nxt   = FINISH;
            timeout_set = !abort_i;
          end
`endif
        end
      end
      RD_RES:    if (idx == 4'd9) state_nxt = RD_LAST;
      RD_LAST:   state_nxt = FINISH;
      FINISH:    state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    if (abort_i) state_nxt = IDLE;
  end

  // Bus and status outputs decoded from the current state and beat index.
  always_comb begin
    read_o      = 1'b0;
    write_o     = 1'b0;
    address_o   = 4'd0;
    writedata_o = 32'd0;
    busy_o      = (state != IDLE) && (state != FINISH);
    done_o      = (state == FINISH);
    case (state)
      WR_PARAM: begin
        write_o   = 1'b1;
        address_o = idx + 4'd1;
        case (idx)
          4'd0:    writedata_o = params[1];
          4'd1:    writedata_o = params[2];
          default: writedata_o = params[3];
        endcase
      end
      WR_START: begin
        write_o     = 1'b1;
        writedata_o = 32'h1;
      end
      POLL_RD: begin
        read_o    = 1'b1;
        address_o = 4'd4;
      end
      RD_RES: begin
        read_o    = 1'b1;
        address_o = idx + 4'd5;
      end
      default: ;
    endcase
  end

  // State register, beat/wait counters and parameter capture.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      idx      <= 4'd0;
      wait_cnt <= '0;
      params   <= '0;
    end else begin
      state <= state_nxt;
      if ((state_nxt == state) && (state == WR_PARAM || state == RD_RES)) idx <= idx + 4'd1;
      else idx <= 4'd0;
      if ((state == POLL_WAIT) && (state_nxt == POLL_WAIT)) wait_cnt <= wait_cnt + 1'b1;
      else wait_cnt <= '0;
      if (start_acc) params <= test_param_i;
    end
  end

  // Result capture: each read beat lands one cycle after its address; a beat
  // returning in the abort cycle is still stored, later ones are dropped.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      result_o <= '0;
    end else if (state == RD_RES && idx != 4'd0) begin
      result_o[idx - 4'd1] <= readdata_i;
    end else if (state == RD_LAST) begin
      result_o[9] <= readdata_i;
    end
  end

endmodule

// File: tb/tb_csr_test_host.sv
// tb_csr_test_host: table-driven runs plus corner sequences for csr_test_host.
// A CSR model answers reads with 1-cycle latency; expected bus accesses are queued at start and popped per access.
// Build with POLL_TIMEOUT_EN defined to exercise the timeout path.
module tb_csr_test_host;

  localparam int PI = 16;
  localparam int TP = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [3:1][31:0]  tparam = '0;
  logic              rd, wr, busy, done, tmo;
  logic [3:0]        addr;
  logic [31:0]       wdat;
  logic [31:0]       rdat = 32'h0;
  logic [9:0][31:0]  res;

  always #5 clk = ~clk;

  csr_test_host #(.POLL_INTERVAL(PI), .TIMEOUT_POLLS(TP)) dut (
    .clk_sys_i(clk), .rst_n_i(rst_n), .start_i(start), .abort_i(abort),
    .test_param_i(tparam), .read_o(rd), .write_o(wr), .address_o(addr),
    .writedata_o(wdat), .readdata_i(rdat), .busy_o(busy), .done_o(done),
    .timeout_o(tmo), .result_o(res)
  );

  typedef struct {
    logic        rd;
    logic [3:0]  addr;
    logic [31:0] data;
    int          gap;   // cycles since previous access (or since start sampling), -1 = unchecked
  } acc_t;

  typedef struct {
    logic [31:0] p3, p2, p1;
    int          polls;
    logic [31:0] base;
    logic [31:0] r0, r9;
  } vec_t;

  acc_t        exp_q[$];
  int          n_pass = 0, n_total = 0;
  int          cyc = 0, last_cyc = 0;
  int          done_cnt = 0, acc_cnt = 0;
  logic        tmo_at_done = 1'b0, busy_at_done = 1'b0;
  int          polls_seen = 0, poll_base = 0, status_after = 0;
  logic [31:0] reg_base = 32'h0;
  logic [31:0] exp_res [10];

  // CSR model: status bit 0 set on the status_after-th poll of a run; result regs = reg_base + address.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd && addr == 4'd4) begin
      polls_seen <= polls_seen + 1;
      rdat <= {31'h0, (status_after != 0) && (polls_seen + 1 - poll_base == status_after)};
    end else if (rd) begin
      rdat <= reg_base + 32'(addr);
    end else begin
      rdat <= 32'hBAD0_BAD0;
    end
  end

  // Monitor: done pulses and bus accesses against the expected queue.
  acc_t e;
  int   gap;
  logic ok;
  always @(negedge clk) begin
    if (done) begin
      done_cnt     = done_cnt + 1;
      tmo_at_done  = tmo;
      busy_at_done = busy;
    end
    if (rd || wr) begin
      acc_cnt = acc_cnt + 1;
      n_total = n_total + 1;
      if (exp_q.size() == 0) begin
        $display("FAIL bus_unexpected: got rd=%0b wr=%0b addr=%0d data=%h, required no access", rd, wr, addr, wdat);
      end else begin
        e   = exp_q.pop_front();
        gap = cyc - last_cyc;
        ok  = (rd === e.rd) && (wr === !e.rd) && (addr === e.addr) &&
              (e.rd || wdat === e.data) && (e.gap < 0 || gap == e.gap);
        if (ok) n_pass = n_pass + 1;
        else $display("FAIL bus_access: got rd=%0b wr=%0b addr=%0d data=%h gap=%0d, required rd=%0b addr=%0d data=%h gap=%0d",
                      rd, wr, addr, wdat, gap, e.rd, e.addr, e.data, e.gap);
      end
      last_cyc = cyc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total = n_total + 1;
    if (act === req) n_pass = n_pass + 1;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  task automatic chk_results(input string name);
    for (int i = 0; i < 10; i++) chk($sformatf("%s_res%0d", name, i), res[i], exp_res[i]);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_read"}, 32'(rd), 0);
    chk({name, "_write"}, 32'(wr), 0);
    chk({name, "_addr"}, 32'(addr), 0);
    chk({name, "_wdata"}, wdat, 0);
    chk({name, "_busy"}, 32'(busy), 0);
    chk({name, "_done"}, 32'(done), 0);
    chk({name, "_timeout"}, 32'(tmo), 0);
  endtask

  // Expected accesses of one run: 4 writes, npolls status reads, nreads result reads.
  task automatic push_seq(input logic [31:0] p3, p2, p1, input int npolls, input int nreads);
    exp_q.push_back('{1'b0, 4'd1, p1, 1});
    exp_q.push_back('{1'b0, 4'd2, p2, 1});
    exp_q.push_back('{1'b0, 4'd3, p3, 1});
    exp_q.push_back('{1'b0, 4'd0, 32'h1, 1});
    for (int i = 0; i < npolls; i++) exp_q.push_back('{1'b1, 4'd4, 32'h0, (i == 0) ? PI + 1 : PI + 2});
    for (int i = 0; i < nreads; i++) exp_q.push_back('{1'b1, 4'(5 + i), 32'h0, (i == 0) ? 2 : 1});
  endtask

  task automatic pulse_start(input logic [31:0] p3, p2, p1, input logic track, input logic with_abort);
    @(posedge clk); #1;
    tparam[3] = p3; tparam[2] = p2; tparam[1] = p1;
    start = 1'b1;
    abort = with_abort;
    if (track) begin
      last_cyc  = cyc;
      poll_base = polls_seen;
    end
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done_cnt != d0) break;
    end
    chk({name, "_done_pulses"}, 32'(done_cnt - d0), 1);
  endtask

  vec_t vecs [3];
  int   d0, a0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'hA5A5_0003, 32'h0000_1000, 32'hDEAD_BEEF, 3, 32'h100, 32'h105, 32'h10E};
    vecs[1] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 1, 32'h200, 32'h205, 32'h20E};
    vecs[2] = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 2, 32'hC000_0000, 32'hC000_0005, 32'hC000_000E};
    for (int i = 0; i < 10; i++) exp_res[i] = 32'h0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    chk_results("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Table-driven complete sequences.
    for (int v = 0; v < 3; v++) begin
      status_after = vecs[v].polls;
      reg_base     = vecs[v].base;
      push_seq(vecs[v].p3, vecs[v].p2, vecs[v].p1, vecs[v].polls, 10);
      pulse_start(vecs[v].p3, vecs[v].p2, vecs[v].p1, 1'b1, 1'b0);
      wait_done($sformatf("vec%0d", v), 600);
      chk($sformatf("vec%0d_timeout", v), 32'(tmo_at_done), 0);
      chk($sformatf("vec%0d_busy_at_done", v), 32'(busy_at_done), 0);
      chk($sformatf("vec%0d_r0", v), res[0], vecs[v].r0);
      chk($sformatf("vec%0d_r9", v), res[9], vecs[v].r9);
      for (int i = 0; i < 10; i++) exp_res[i] = vecs[v].base + 32'(5 + i);
      chk_results($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_queue_left", v), 32'(exp_q.size()), 0);
    end

`ifdef POLL_TIMEOUT_EN
    // Status never set: exactly TP polls, then done with timeout, results untouched.
    status_after = 0;
    push_seq(32'h3, 32'h2, 32'h1, TP, 0);
    pulse_start(32'h3, 32'h2, 32'h1, 1'b1, 1'b0);
    wait_done("tmo", 600);
    chk("tmo_timeout_at_done", 32'(tmo_at_done), 1);
    chk("tmo_level_after", 32'(tmo), 1);
    chk_results("tmo");
    chk("tmo_queue_left", 32'(exp_q.size()), 0);
    // The next accepted start clears timeout.
    status_after = 1;
    reg_base     = 32'h500;
    push_seq(32'h33, 32'h22, 32'h11, 1, 10);
    pulse_start(32'h33, 32'h22, 32'h11, 1'b1, 1'b0);
    @(negedge clk);
    chk("tmo_cleared_on_start", 32'(tmo), 0);
    wait_done("tmo_next", 600);
    for (int i = 0; i < 10; i++) exp_res[i] = 32'h500 + 32'(5 + i);
    chk_results("tmo_next");
`else
    // Status never set: polling continues past many reads with no timeout.
    status_after = 0;
    push_seq(32'h3, 32'h2, 32'h1, 6, 0);
    pulse_start(32'h3, 32'h2, 32'h1, 1'b1, 1'b0);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    chk("nopoll_queue_left", 32'(exp_q.size()), 0);
    repeat (3) @(negedge clk);
    chk("nopoll_timeout", 32'(tmo), 0);
    chk("nopoll_still_busy", 32'(busy), 1);
    d0 = done_cnt;
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("nopoll_abort_busy", 32'(busy), 0);
    chk("nopoll_abort_no_done", 32'(done_cnt - d0), 0);
    chk_results("nopoll");
`endif

    // Abort during the 5th result read (address 9).
    status_after = 1;
    reg_base     = 32'h600;
    push_seq(32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001, 1, 5);
    pulse_start(32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001, 1'b1, 1'b0);
    d0 = done_cnt;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rd && addr == 4'd9) break;
    end
    #2 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_read", 32'(rd), 0);
    chk("abort_write", 32'(wr), 0);
    chk("abort_busy", 32'(busy), 0);
    repeat (5) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - d0), 0);
    for (int i = 0; i < 4; i++) exp_res[i] = 32'h600 + 32'(5 + i);
    chk_results("abort");
    chk("abort_queue_left", 32'(exp_q.size()), 0);

    // Start pulsed during POLL_WAIT is ignored; the run completes normally.
    status_after = 2;
    reg_base     = 32'h700;
    push_seq(32'h7003, 32'h7002, 32'h7001, 2, 10);
    pulse_start(32'h7003, 32'h7002, 32'h7001, 1'b1, 1'b0);
    repeat (8) @(posedge clk);
    pulse_start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wait_done("busy_start", 600);
    for (int i = 0; i < 10; i++) exp_res[i] = 32'h700 + 32'(5 + i);
    chk_results("busy_start");
    chk("busy_start_queue_left", 32'(exp_q.size()), 0);

    // Start together with abort in IDLE: nothing happens.
    a0 = acc_cnt;
    d0 = done_cnt;
    pulse_start(32'h1, 32'h2, 32'h3, 1'b0, 1'b1);
    repeat (30) @(negedge clk);
    chk("start_abort_accesses", 32'(acc_cnt - a0), 0);
    chk("start_abort_busy", 32'(busy), 0);
    chk("start_abort_done", 32'(done_cnt - d0), 0);

    // Reset during WR_PARAM clears everything at once; a new start restarts from address 1.
    exp_q.push_back('{1'b0, 4'd1, 32'h8001, 1});
    pulse_start(32'h8003, 32'h8002, 32'h8001, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wr) break;
    end
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    for (int i = 0; i < 10; i++) exp_res[i] = 32'h0;
    chk_results("midreset");
    chk("midreset_queue_left", 32'(exp_q.size()), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    status_after = 1;
    reg_base     = 32'h800;
    push_seq(32'hA5A5_0003, 32'h0000_1000, 32'hDEAD_BEEF, 1, 10);
    pulse_start(32'hA5A5_0003, 32'h0000_1000, 32'hDEAD_BEEF, 1'b1, 1'b0);
    wait_done("after_reset", 600);
    for (int i = 0; i < 10; i++) exp_res[i] = 32'h800 + 32'(5 + i);
    chk_results("after_reset");
    chk("after_reset_queue_left", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
